stream_rr_arbiter: RTL and testbench
====================================

# stream_rr_arbiter

Packet-granular round-robin arbiter that shares one 64-bit valid/ready/keep/last stream output between `NUM_IN` stream sources. It sits in front of a single-input stream consumer, such as a packet parser or a loopback passthrough. Once a source is granted, it owns the output for a whole packet, so packets are never interleaved. A per-source enable mask lets control logic take sources in and out of arbitration at packet boundaries.

## Interface

Parameters:
- `NUM_IN`, default 4: number of source streams, 2..8.
- `DATA_WIDTH`, default 64: beat width; `KEEP_WIDTH = DATA_WIDTH/8`.
- `GID_W`, default 2: grant index width, equal to clog2(`NUM_IN`).

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stream_in_DATA`  in  NUM_IN*DATA_WIDTH  source data; source i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- `stream_in_KEEP`  in  NUM_IN*KEEP_WIDTH  source byte enables.
- `stream_in_LAST`  in  NUM_IN  end-of-packet flag per source.
- `stream_in_VALID`  in  NUM_IN  beat valid per source.
- `stream_in_READY`  out  NUM_IN  beat accept per source.
- `src_enable`  in  NUM_IN  1 = source may be granted.
- `stream_out_DATA`  out  DATA_WIDTH  registered output data.
- `stream_out_KEEP`  out  KEEP_WIDTH  registered output keep.
- `stream_out_LAST`  out  1  registered output last.
- `stream_out_VALID`  out  1  registered output valid.
- `stream_out_READY`  in  1  downstream accept.
- `grant_valid`  out  1  high while a packet is owned (BUSY).
- `grant_id`  out  GID_W  index of the current or most recent owner.

## Operation

- The FSM has two states, IDLE and BUSY.
- **IDLE:**
  - Request vector = `stream_in_VALID & src_enable`.
  - If the request vector is nonzero, pick the first requesting index, searching from `last_grant+1` upward with wrap modulo `NUM_IN`.
  - Register the pick into `grant_id` and `last_grant`, then go to BUSY.
  - No beat is accepted in IDLE.
- **BUSY:**
  - `stream_in_READY[grant_id] = !stream_out_VALID || stream_out_READY`.
  - All other READY bits are 0.
  - On a handshake from the granted source, its DATA, KEEP and LAST load into the output register and `stream_out_VALID` is set.
  - If the handshaken beat has LAST=1, go to IDLE on the next cycle.
- **Output register:**
  - `stream_out_VALID` clears when the beat is accepted (`stream_out_READY`=1) and no new beat loads in the same cycle.
  - Simultaneous drain and load keeps VALID at 1 with the new beat.
- **Enable mask:**
  - `src_enable` is sampled only in IDLE.
  - Deasserting the current owner's enable during BUSY does not abort its packet; the packet completes.
- Sources whose VALID is low are skipped, with no starvation. A source that keeps requesting is granted within `NUM_IN` arbitration rounds.
- Single-beat packets (LAST on the first beat) are legal.

## Timing

- Values out of reset:
  - All `stream_in_READY` = 0.
  - `stream_out_VALID` = 0; `stream_out_DATA`, `stream_out_KEEP` and `stream_out_LAST` = 0.
  - `grant_valid` = 0 and `grant_id` = 0.
  - State = IDLE; `last_grant` = `NUM_IN-1`, so source 0 has first priority.
- Reset mid-packet drops the output register contents and ownership immediately. Upstream sources must restart their packets.
- Arbitration costs 1 idle cycle per packet: a request seen in IDLE at cycle N gives the first possible handshake at cycle N+1.
- Input-to-output latency is 1 cycle: a beat accepted at edge N is valid on `stream_out_*` after edge N.
- With downstream READY held high, an L-beat packet occupies L+1 cycles, including the arbitration cycle.
- The READY logic is combinational from `stream_out_READY` and `stream_out_VALID`. There is no combinational path from `stream_in_VALID` to `stream_in_READY`.
- When the LAST beat is handshaken at edge N, the state is IDLE after edge N. The next grant registers at edge N+1.
- The output register may still hold the LAST beat when the next owner's first beat arrives. That first beat waits on the usual READY rule.
- Output beats are never dropped or duplicated under any pattern of downstream READY.
- DATA, KEEP and LAST are held stable while VALID=1 and READY=0.

## Test plan

- **Single source, full rate:** NUM_IN=4; source 0 sends 3 beats (0x11, 0x22, 0x33, LAST on 0x33), out_READY=1.
  - Required: outputs appear on cycles 2..4 after the request; `grant_id`=0; READY[1..3] stay 0.
- **Round robin:** sources 0..3 each hold a 2-beat packet valid at the same time.
  - Required: output packet order is 0,1,2,3; no interleaving; 12 cycles total.
  - Required: a second batch in which all four sources request again is also served in order 0,1,2,3.
- **Backpressure:** out_READY toggles 1,0,0,1,... during a 4-beat packet from source 2.
  - Required: output data stable while stalled; all 4 beats delivered in order; KEEP 0xFF,0xFF,0xFF,0x0F passed unchanged.
- **Enable mask:** `src_enable`=4'b1010 with all four sources valid.
  - Required: only sources 1 and 3 are granted, alternately.
  - Clearing bit 3 while source 3 is mid-packet must not stop that packet from completing.
- **Single-beat packets:** single-beat packets back-to-back from sources 0 and 1.
  - Required: each takes 2 cycles; `grant_valid` pulses once per packet.
- **Reset mid-packet:** assert `rst` for 1 cycle after beat 2 of 5.
  - Required: `stream_out_VALID`=0 and all READY=0 immediately.
  - Required: the next request from source 0 is granted first.

Source files
------------

// File: rtl/stream_rr_arbiter_if.sv
// Bundle of every handshake and status signal around stream_rr_arbiter.
// The arbiter uses the slave modport; sources, sink and control logic use master.
//   stream_in_*  : NUM_IN packed valid/ready/keep/last sources (source i at slice i)
//   src_enable   : per-source arbitration enable
//   stream_out_* : single registered output stream
//   grant_valid  : a packet is currently owned
//   grant_id     : current or most recent owner
interface stream_rr_arbiter_if #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int GID_W      = 2
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [NUM_IN*DATA_WIDTH-1:0] stream_in_DATA;
  logic [NUM_IN*KEEP_WIDTH-1:0] stream_in_KEEP;
  logic [NUM_IN-1:0]            stream_in_LAST;
  logic [NUM_IN-1:0]            stream_in_VALID;
  logic [NUM_IN-1:0]            stream_in_READY;
  logic [NUM_IN-1:0]            src_enable;
  logic [DATA_WIDTH-1:0]        stream_out_DATA;
  logic [KEEP_WIDTH-1:0]        stream_out_KEEP;
  logic                         stream_out_LAST;
  logic                         stream_out_VALID;
  logic                         stream_out_READY;
  logic                         grant_valid;
  logic [GID_W-1:0]             grant_id;

  modport slave (
    input  stream_in_DATA, stream_in_KEEP, stream_in_LAST, stream_in_VALID,
    input  src_enable, stream_out_READY,
    output stream_in_READY, stream_out_DATA, stream_out_KEEP, stream_out_LAST,
    output stream_out_VALID, grant_valid, grant_id
  );

  modport master (
    output stream_in_DATA, stream_in_KEEP, stream_in_LAST, stream_in_VALID,
    output src_enable, stream_out_READY,
    input  stream_in_READY, stream_out_DATA, stream_out_KEEP, stream_out_LAST,
    input  stream_out_VALID, grant_valid, grant_id
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin arbiter: NUM_IN valid/ready/keep/last sources
// share one registered output stream. A granted source owns the output until
// its LAST beat is accepted, so packets never interleave.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - stream_rr_arbiter_if.slave: source streams, src_enable, output
//          stream, grant_valid / grant_id status
module stream_rr_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int GID_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  stream_rr_arbiter_if.slave bus
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [GID_W-1:0]      grant_id_q, grant_id_d;
  logic [GID_W-1:0]      last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] data_p1_q, data_p1_d;
  logic [KEEP_WIDTH-1:0] keep_p1_q, keep_p1_d;
  logic                  last_p1_q, last_p1_d;
  logic                  vld_p1_q, vld_p1_d;

  logic [NUM_IN-1:0]     req;
  logic [NUM_IN-1:0]     in_ready;
  logic [GID_W-1:0]      pick_idx;
  logic [GID_W-1:0]      pick_id;
  logic                  pick_found;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  sel_last;
  logic                  sel_valid;
  logic                  busy;
  logic                  out_free;
  logic                  hs;

  assign req      = bus.stream_in_VALID & bus.src_enable;
  assign busy     = (state_q == BUSY);
  // READY depends only on owner state and the output register, never on
  // stream_in_VALID, so no valid-to-ready combinational path exists.
  assign out_free = !vld_p1_q || bus.stream_out_READY;
  assign hs       = busy && out_free && sel_valid;

  // Rotating search starting just after the previous winner, wrapping at
  // NUM_IN (which need not be a power of two).
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_idx   = last_grant_q;
    for (int k = 0; k < NUM_IN; k++) begin
      pick_idx = (pick_idx == GID_W'(NUM_IN - 1)) ? '0 : pick_idx + 1'b1;
      if (!pick_found && req[pick_idx]) begin
        pick_found = 1'b1;
        pick_id    = pick_idx;
      end
    end
  end

  // Owner mux and per-source ready
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    in_ready  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_id_q == GID_W'(i)) begin
        sel_data    = bus.stream_in_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep    = bus.stream_in_KEEP[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_last    = bus.stream_in_LAST[i];
        sel_valid   = bus.stream_in_VALID[i];
        in_ready[i] = busy && out_free;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    data_p1_d    = data_p1_q;
    keep_p1_d    = keep_p1_q;
    last_p1_d    = last_p1_q;
    vld_p1_d     = vld_p1_q && !bus.stream_out_READY;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d   = pick_id;
          last_grant_d = pick_id;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        // A load overrides the drain, so drain+load keeps VALID high.
        if (hs) begin
          data_p1_d = sel_data;
          keep_p1_d = sel_keep;
          last_p1_d = sel_last;
          vld_p1_d  = 1'b1;
          if (sel_last) begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // ---- stage p1: arbitration state and output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= GID_W'(NUM_IN - 1);
      data_p1_q    <= '0;
      keep_p1_q    <= '0;
      last_p1_q    <= 1'b0;
      vld_p1_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      data_p1_q    <= data_p1_d;
      keep_p1_q    <= keep_p1_d;
      last_p1_q    <= last_p1_d;
      vld_p1_q     <= vld_p1_d;
    end
  end

  assign bus.stream_in_READY  = in_ready;
  assign bus.stream_out_DATA  = data_p1_q;
  assign bus.stream_out_KEEP  = keep_p1_q;
  assign bus.stream_out_LAST  = last_p1_q;
  assign bus.stream_out_VALID = vld_p1_q;
  assign bus.grant_valid      = busy;
  assign bus.grant_id         = grant_id_q;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
module tb_stream_rr_arbiter;
  localparam int NUM_IN = 4;
  localparam int DATA_WIDTH = 64;
  localparam int GID_W = 2;
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_rr_arbiter_if #(.NUM_IN(NUM_IN), .DATA_WIDTH(DATA_WIDTH), .GID_W(GID_W)) bus ();
  stream_rr_arbiter #(.NUM_IN(NUM_IN), .DATA_WIDTH(DATA_WIDTH), .GID_W(GID_W)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
  } beat_t;

  typedef struct {
    logic [3:0] vld; logic [7:0] dat; logic lst; logic ordy;
    logic ovld; logic [7:0] odat; logic olast; logic gv; logic [1:0] gid; logic [3:0] irdy;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  beat_t src_q[NUM_IN][$];
  beat_t exp_q[$];
  beat_t got_q[$];
  int    gnt_q[$];
  int    seq = 0;
  int    vld_pct = 100;
  int    ordy_mode = 0;
  int    pat_cnt = 0;
  int    gv_hi = 0;
  bit    drv_en = 0;
  bit    mon_en = 0;
  bit    gv_prev = 0;
  // reference model state: who owns the output, who won last, output reg full
  bit    m_busy;
  int    m_owner;
  int    m_last;
  bit    m_ovld;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_IN-1:0] req, input int last);
    for (int k = 1; k <= NUM_IN; k++) begin
      int j;
      j = (last + k) % NUM_IN;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NUM_IN; i++) if (src_q[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic make_pkt(input int src, input int len, input logic [7:0] last_keep);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {8'(src), 8'(seq), 16'(k), 32'($urandom)};
      b.keep = (k == len - 1) ? last_keep : 8'hFF;
      b.last = (k == len - 1);
      src_q[src].push_back(b);
    end
    seq++;
  endtask

  task automatic clear_inputs();
    bus.stream_in_DATA = '0;
    bus.stream_in_KEEP = '0;
    bus.stream_in_LAST = '0;
    bus.stream_in_VALID = '0;
    bus.src_enable = '1;
    bus.stream_out_READY = 1'b1;
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = NUM_IN - 1; m_ovld = 0;
    exp_q.delete(); gnt_q.delete(); got_q.delete(); gv_prev = 0;
  endtask

  task automatic drive(input logic [NUM_IN-1:0] hs);
    for (int i = 0; i < NUM_IN; i++) begin
      logic hold;
      hold = bus.stream_in_VALID[i] && !hs[i];
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (!hold) begin
        if (src_q[i].size() > 0 && $urandom_range(0, 99) < vld_pct) begin
          bus.stream_in_VALID[i] = 1'b1;
          bus.stream_in_DATA[i*DATA_WIDTH +: DATA_WIDTH] = src_q[i][0].data;
          bus.stream_in_KEEP[i*KEEP_WIDTH +: KEEP_WIDTH] = src_q[i][0].keep;
          bus.stream_in_LAST[i] = src_q[i][0].last;
        end else begin
          bus.stream_in_VALID[i] = 1'b0;
        end
      end
    end
    case (ordy_mode)
      1:       bus.stream_out_READY = ($urandom_range(0, 99) < 65);
      2:       bus.stream_out_READY = (pat_cnt % 3 == 0);
      default: bus.stream_out_READY = 1'b1;
    endcase
    pat_cnt++;
  endtask

  // Behavioural model evaluated just before each rising edge.
  task automatic model_step();
    logic [NUM_IN-1:0] exp_rdy;
    bit rdy_ok;
    int p;
    chk("grant_valid", bus.grant_valid, m_busy);
    chk("grant_id", bus.grant_id, m_owner);
    rdy_ok = !m_ovld || bus.stream_out_READY;
    exp_rdy = '0;
    if (m_busy && rdy_ok) exp_rdy[m_owner] = 1'b1;
    chk("in_ready", bus.stream_in_READY, exp_rdy);
    chk("out_valid", bus.stream_out_VALID, m_ovld);
    if (m_ovld && exp_q.size() > 0) begin
      chk("out_data", bus.stream_out_DATA, exp_q[0].data);
      chk("out_keep", bus.stream_out_KEEP, exp_q[0].keep);
      chk("out_last", bus.stream_out_LAST, exp_q[0].last);
      if (bus.stream_out_READY) void'(exp_q.pop_front());
    end
    if (m_busy) begin
      if (bus.stream_in_VALID[m_owner] && rdy_ok && src_q[m_owner].size() > 0) begin
        exp_q.push_back(src_q[m_owner][0]);
        m_ovld = 1;
        if (src_q[m_owner][0].last) m_busy = 0;
      end else if (bus.stream_out_READY) begin
        m_ovld = 0;
      end
    end else begin
      if (bus.stream_out_READY) m_ovld = 0;
      p = rr_pick(bus.stream_in_VALID & bus.src_enable, m_last);
      if (p >= 0) begin
        m_owner = p; m_last = p; m_busy = 1;
      end
    end
  endtask

  task automatic cycle();
    logic [NUM_IN-1:0] hs;
    @(negedge clk);
    hs = bus.stream_in_VALID & bus.stream_in_READY;
    if (bus.grant_valid && !gv_prev) gnt_q.push_back(int'(bus.grant_id));
    gv_prev = bus.grant_valid;
    if (bus.grant_valid) gv_hi++;
    if (bus.stream_out_VALID && bus.stream_out_READY)
      got_q.push_back({bus.stream_out_DATA, bus.stream_out_KEEP, bus.stream_out_LAST});
    if (mon_en) model_step();
    @(posedge clk);
    #1;
    if (drv_en) drive(hs);
  endtask

  task automatic run_until_empty(input int bound, output int n);
    n = 0;
    while (!all_empty() && n < bound) begin
      cycle();
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    for (int i = 0; i < NUM_IN; i++) src_q[i].delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    gv_hi = 0; pat_cnt = 0; ordy_mode = 0; vld_pct = 100;
  endtask

  vec_t tbl[19];
  int n;
  int total;
  beat_t bp_exp[$];

  initial begin
    tbl = '{
      '{4'h1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 4'h0},
      '{4'h1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 4'h1},
      '{4'h1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 2'd0, 4'h1},
      '{4'h1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 2'd0, 4'h1},
      '{4'h0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 2'd0, 4'h0},
      '{4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 4'h0},
      '{4'h1, 8'h44, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 4'h0},
      '{4'h1, 8'h44, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 4'h1},
      '{4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 2'd0, 4'h0},
      '{4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 2'd0, 4'h0},
      '{4'h0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 2'd0, 4'h0},
      '{4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 4'h0},
      '{4'h1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 4'h0},
      '{4'h1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 4'h1},
      '{4'h1, 8'h66, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 2'd0, 4'h0},
      '{4'h1, 8'h66, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 2'd0, 4'h1},
      '{4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 1'b0, 2'd0, 4'h0},
      '{4'h0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 2'd0, 4'h0},
      '{4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 4'h0}
    };

    // reset values
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.stream_in_READY, 4'h0);
    chk("rst_out_valid", bus.stream_out_VALID, 1'b0);
    chk("rst_out_data", bus.stream_out_DATA, 64'h0);
    chk("rst_out_keep_last", {bus.stream_out_KEEP, bus.stream_out_LAST}, 9'h0);
    chk("rst_grant_valid", bus.grant_valid, 1'b0);
    chk("rst_grant_id", bus.grant_id, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // table-driven: single source full rate, stall, drain+load
    for (int r = 0; r < 19; r++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        bus.stream_in_DATA[i*DATA_WIDTH +: DATA_WIDTH] = {56'h0, tbl[r].dat};
        bus.stream_in_KEEP[i*KEEP_WIDTH +: KEEP_WIDTH] = 8'hFF;
      end
      bus.stream_in_LAST = tbl[r].lst ? 4'hF : 4'h0;
      bus.stream_in_VALID = tbl[r].vld;
      bus.stream_out_READY = tbl[r].ordy;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", r), bus.stream_in_READY, tbl[r].irdy);
      chk($sformatf("tbl%0d_grant_valid", r), bus.grant_valid, tbl[r].gv);
      chk($sformatf("tbl%0d_grant_id", r), bus.grant_id, tbl[r].gid);
      chk($sformatf("tbl%0d_out_valid", r), bus.stream_out_VALID, tbl[r].ovld);
      if (tbl[r].ovld) begin
        chk($sformatf("tbl%0d_out_data", r), bus.stream_out_DATA, {56'h0, tbl[r].odat});
        chk($sformatf("tbl%0d_out_last", r), bus.stream_out_LAST, tbl[r].olast);
      end
      @(posedge clk);
      #1;
    end

    drv_en = 1;
    mon_en = 1;

    // round robin, two batches
    do_reset();
    for (int b = 0; b < 2; b++) begin
      gnt_q.delete();
      for (int s = 0; s < NUM_IN; s++) make_pkt(s, 2, 8'hFF);
      drive('0);
      run_until_empty(100, n);
      chk($sformatf("rr%0d_cycles", b), n, 12);
      chk($sformatf("rr%0d_grants", b), gnt_q.size(), 4);
      for (int k = 0; k < gnt_q.size() && k < 4; k++)
        chk($sformatf("rr%0d_order%0d", b, k), gnt_q[k], k);
    end
    repeat (2) cycle();

    // backpressure 1,0,0 on a 4-beat packet from source 2
    do_reset();
    ordy_mode = 2;
    make_pkt(2, 4, 8'h0F);
    bp_exp = src_q[2];
    drive('0);
    run_until_empty(60, n);
    for (int k = 0; k < 10 && got_q.size() < 4; k++) cycle();
    chk("bp_beats", got_q.size(), 4);
    for (int k = 0; k < got_q.size() && k < 4; k++) begin
      chk($sformatf("bp_data%0d", k), got_q[k].data, bp_exp[k].data);
      chk($sformatf("bp_keep%0d", k), got_q[k].keep, (k == 3) ? 8'h0F : 8'hFF);
    end

    // enable mask 1010 with all sources valid
    do_reset();
    bus.src_enable = 4'b1010;
    for (int s = 0; s < NUM_IN; s++) begin make_pkt(s, 2, 8'hFF); make_pkt(s, 2, 8'hFF); end
    drive('0);
    repeat (14) cycle();
    chk("en_grants", gnt_q.size(), 4);
    for (int k = 0; k < gnt_q.size() && k < 4; k++)
      chk($sformatf("en_order%0d", k), gnt_q[k], (k % 2 == 0) ? 1 : 3);
    chk("en_skip0", src_q[0].size(), 4);
    chk("en_skip2", src_q[2].size(), 4);

    // owner disabled mid-packet still completes
    do_reset();
    bus.src_enable = 4'b1010;
    make_pkt(3, 4, 8'hFF);
    drive('0);
    repeat (2) cycle();
    bus.src_enable = 4'b0010;
    run_until_empty(40, n);
    repeat (3) cycle();
    chk("dis_beats", got_q.size(), 4);
    chk("dis_grants", gnt_q.size(), 1);
    if (gnt_q.size() > 0) chk("dis_owner", gnt_q[0], 3);

    // single-beat packets back to back from sources 0 and 1
    do_reset();
    make_pkt(0, 1, 8'hFF); make_pkt(0, 1, 8'hFF);
    make_pkt(1, 1, 8'hFF); make_pkt(1, 1, 8'hFF);
    drive('0);
    run_until_empty(40, n);
    chk("sb_cycles", n, 8);
    chk("sb_grant_pulses", gnt_q.size(), 4);
    chk("sb_grant_high_cycles", gv_hi, 4);
    for (int k = 0; k < gnt_q.size() && k < 4; k++)
      chk($sformatf("sb_order%0d", k), gnt_q[k], k % 2);
    repeat (2) cycle();

    // reset after beat 2 of 5
    do_reset();
    make_pkt(0, 5, 8'hFF);
    drive('0);
    for (int k = 0; k < 20 && src_q[0].size() > 3; k++) cycle();
    chk("mid_beats_taken", src_q[0].size(), 3);
    mon_en = 0;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.stream_out_VALID, 1'b0);
    chk("mid_rst_in_ready", bus.stream_in_READY, 4'h0);
    chk("mid_rst_grant_valid", bus.grant_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    for (int i = 0; i < NUM_IN; i++) src_q[i].delete();
    model_reset();
    mon_en = 1;
    make_pkt(1, 2, 8'hFF);
    make_pkt(0, 2, 8'hFF);
    drive('0);
    run_until_empty(40, n);
    chk("mid_next_grants", gnt_q.size(), 2);
    if (gnt_q.size() > 0) chk("mid_first_grant", gnt_q[0], 0);
    repeat (2) cycle();

    // randomized traffic against the model
    do_reset();
    vld_pct = 70;
    ordy_mode = 1;
    total = 0;
    for (int s = 0; s < NUM_IN; s++)
      for (int p = 0; p < 15; p++) begin
        int len;
        len = $urandom_range(1, 4);
        total += len;
        make_pkt(s, len, 8'($urandom_range(1, 255)));
      end
    drive('0);
    for (int c = 0; c < 1500 && !all_empty(); c++) begin
      if ($urandom_range(0, 19) == 0) bus.src_enable = 4'($urandom_range(0, 15));
      cycle();
    end
    bus.src_enable = 4'hF;
    ordy_mode = 0;
    run_until_empty(500, n);
    chk("rand_sources_drained", all_empty(), 1'b1);
    repeat (4) cycle();
    chk("rand_beats_delivered", got_q.size(), total);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
